// File: rtl/mdac_tdm_pkg.sv
// Shared constants for the time-multiplexed signed x unsigned multiplier array:
// default widths, FSM encodings and width helpers.
package mdac_tdm_pkg;

  localparam int DEF_SIG_W    = 12;
  localparam int DEF_COEF_W   = 8;
  localparam int DEF_CHANNELS = 3;
  localparam int DEF_SHIFT    = 4;
  localparam int DEF_OUT_W    = 16;
  localparam int DEF_ROUND    = 0;
  localparam int DEF_SAT      = 0;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RUN     = 2'd1;
  localparam logic [1:0] ST_PUBLISH = 2'd2;

  // Working width for formatting: product plus rounding guard bit, widened so
  // the output range and its saturation limits are always representable.
  function automatic int fmt_width(input int prod_w, input int out_w);
    return ((prod_w + 1 > out_w) ? prod_w + 1 : out_w) + 1;
  endfunction

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mdac_tdm_mult_sxu_reg.sv
// One-stage registered signed x unsigned multiplier; the unsigned operand is
// zero-extended so the product is a plain signed value of SIG_W+COEF_W bits.
module mult_sxu_reg
  import mdac_tdm_pkg::*;
#(
  parameter int SIG_W  = DEF_SIG_W,
  parameter int COEF_W = DEF_COEF_W
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            en,
  input  logic signed [SIG_W-1:0]         sig,
  input  logic        [COEF_W-1:0]        coef,
  output logic signed [SIG_W+COEF_W-1:0]  prod
);

  localparam int PROD_W = SIG_W + COEF_W;

  logic signed [PROD_W-1:0] sig_ext;
  logic signed [PROD_W-1:0] coef_ext;

  assign sig_ext  = PROD_W'(sig);
  assign coef_ext = PROD_W'($signed({1'b0, coef}));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod <= '0;
    end else if (en) begin
      prod <= sig_ext * coef_ext;
    end
  end

endmodule

// File: rtl/mdac_tdm.sv
// Snapshots CHANNELS operand pairs on a start strobe, multiplies them one per
// cycle through a shared multiplier and publishes the formatted vector at once.
module mdac_tdm
  import mdac_tdm_pkg::*;
#(
  parameter int SIG_W    = DEF_SIG_W,
  parameter int COEF_W   = DEF_COEF_W,
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int SHIFT    = DEF_SHIFT,
  parameter int OUT_W    = DEF_OUT_W,
  parameter int ROUND    = DEF_ROUND,
  parameter int SAT      = DEF_SAT
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         iStart,
  input  logic [CHANNELS*SIG_W-1:0]    iSignal,
  input  logic [CHANNELS*COEF_W-1:0]   iCoef,
  input  logic                         iClrOverrun,
  output logic [CHANNELS*OUT_W-1:0]    oOut,
  output logic                         oValid,
  output logic                         oBusy,
  output logic                         oOverrun
);

  localparam int PROD_W = SIG_W + COEF_W;
  localparam int FMT_W  = fmt_width(PROD_W, OUT_W);
  localparam int CNT_W  = cnt_width(CHANNELS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CHANNELS - 1);
  localparam logic signed [FMT_W-1:0] RND_ADD =
    (ROUND != 0 && SHIFT > 0) ? (FMT_W'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
  localparam logic signed [FMT_W-1:0] MAX_V =
    {{(FMT_W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [FMT_W-1:0] MIN_V = ~MAX_V;

  logic [1:0]                      state_reg;
  logic [CNT_W-1:0]                cnt_reg;
  logic [CHANNELS*SIG_W-1:0]       sig_snap_reg;
  logic [CHANNELS*COEF_W-1:0]      coef_snap_reg;
  logic                            issue_vld_reg;
  logic [CNT_W-1:0]                issue_idx_reg;
  logic                            done_reg;
  logic [OUT_W-1:0]                shadow_reg [CHANNELS];
  logic [CHANNELS*OUT_W-1:0]       out_reg;
  logic                            valid_reg;
  logic                            busy_reg;
  logic                            overrun_reg;
  logic signed [PROD_W-1:0]        prod;
  logic signed [SIG_W-1:0]         sig_ch  [CHANNELS];
  logic        [COEF_W-1:0]        coef_ch [CHANNELS];
  logic                            run_en;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_unpack
    assign sig_ch[gi]  = sig_snap_reg[gi*SIG_W +: SIG_W];
    assign coef_ch[gi] = coef_snap_reg[gi*COEF_W +: COEF_W];
  end

  assign run_en = (state_reg == ST_RUN);

  mult_sxu_reg #(
    .SIG_W  (SIG_W),
    .COEF_W (COEF_W)
  ) u_mult (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (run_en),
    .sig   (sig_ch[cnt_reg]),
    .coef  (coef_ch[cnt_reg]),
    .prod  (prod)
  );

  // Round, arithmetic shift, then either clamp or wrap to OUT_W bits.
  function automatic logic [OUT_W-1:0] fmt(input logic signed [PROD_W-1:0] p);
    logic signed [FMT_W-1:0] pe;
    logic signed [FMT_W-1:0] r;
    logic signed [FMT_W-1:0] s;
    pe = FMT_W'(p) + RND_ADD;
    r  = pe >>> SHIFT;
    s  = (r > MAX_V) ? MAX_V : ((r < MIN_V) ? MIN_V : r);
    return (SAT != 0) ? s[OUT_W-1:0] : r[OUT_W-1:0];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_vld_reg <= 1'b0;
      issue_idx_reg <= '0;
      done_reg      <= 1'b0;
      for (int k = 0; k < CHANNELS; k++) shadow_reg[k] <= '0;
    end else begin
      issue_vld_reg <= run_en;
      issue_idx_reg <= cnt_reg;
      done_reg      <= issue_vld_reg && (issue_idx_reg == LAST);
      if (issue_vld_reg) shadow_reg[issue_idx_reg] <= fmt(prod);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      sig_snap_reg  <= '0;
      coef_snap_reg <= '0;
      out_reg       <= '0;
      valid_reg     <= 1'b0;
      busy_reg      <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      valid_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (iStart) begin
            sig_snap_reg  <= iSignal;
            coef_snap_reg <= iCoef;
            cnt_reg       <= '0;
            busy_reg      <= 1'b1;
            state_reg     <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (cnt_reg == LAST) begin
            cnt_reg   <= '0;
            state_reg <= ST_PUBLISH;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        ST_PUBLISH: begin
          // done_reg pulses the cycle after the final slot lands in the shadow.
          if (done_reg) begin
            for (int k = 0; k < CHANNELS; k++) out_reg[k*OUT_W +: OUT_W] <= shadow_reg[k];
            valid_reg <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
      if (iStart && state_reg != ST_IDLE) overrun_reg <= 1'b1;
      else if (iClrOverrun)               overrun_reg <= 1'b0;
    end
  end

  assign oOut     = out_reg;
  assign oValid   = valid_reg;
  assign oBusy    = busy_reg;
  assign oOverrun = overrun_reg;

endmodule

// File: tb/tb_mdac_tdm.sv
// Directed bench for mdac_tdm: default, rounding, shift-0 saturate/wrap and
// single-channel builds run side by side on shared stimulus.
module tb_mdac_tdm;

  logic        clk = 1'b0;
  logic        rst_n, iStart, iClrOverrun;
  logic [35:0] iSignal;
  logic [23:0] iCoef;

  logic [47:0] out_def, out_rnd, out_sat, out_wrp;
  logic [15:0] out_c1;
  logic v_def, v_rnd, v_sat, v_wrp, v_c1;
  logic b_def, b_rnd, b_sat, b_wrp, b_c1;
  logic o_def, o_rnd, o_sat, o_wrp, o_c1;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  mdac_tdm u_def (.clk(clk), .rst_n(rst_n), .iStart(iStart), .iSignal(iSignal), .iCoef(iCoef),
                  .iClrOverrun(iClrOverrun), .oOut(out_def), .oValid(v_def), .oBusy(b_def), .oOverrun(o_def));
  mdac_tdm #(.ROUND(1)) u_rnd (.clk(clk), .rst_n(rst_n), .iStart(iStart), .iSignal(iSignal), .iCoef(iCoef),
                  .iClrOverrun(iClrOverrun), .oOut(out_rnd), .oValid(v_rnd), .oBusy(b_rnd), .oOverrun(o_rnd));
  mdac_tdm #(.SHIFT(0), .SAT(1)) u_sat (.clk(clk), .rst_n(rst_n), .iStart(iStart), .iSignal(iSignal), .iCoef(iCoef),
                  .iClrOverrun(iClrOverrun), .oOut(out_sat), .oValid(v_sat), .oBusy(b_sat), .oOverrun(o_sat));
  mdac_tdm #(.SHIFT(0), .SAT(0)) u_wrp (.clk(clk), .rst_n(rst_n), .iStart(iStart), .iSignal(iSignal), .iCoef(iCoef),
                  .iClrOverrun(iClrOverrun), .oOut(out_wrp), .oValid(v_wrp), .oBusy(b_wrp), .oOverrun(o_wrp));
  mdac_tdm #(.CHANNELS(1)) u_c1 (.clk(clk), .rst_n(rst_n), .iStart(iStart), .iSignal(iSignal[11:0]), .iCoef(iCoef[7:0]),
                  .iClrOverrun(iClrOverrun), .oOut(out_c1), .oValid(v_c1), .oBusy(b_c1), .oOverrun(o_c1));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int s0, input int c0, input int s1, input int c1, input int s2, input int c2);
    iSignal = {12'(s2), 12'(s1), 12'(s0)};
    iCoef   = {8'(c2), 8'(c1), 8'(c0)};
  endtask

  // Pulses iStart, then walks cycles until u_def publishes. Optional extra
  // start / clear at cycle `extra_at`, and operand scrambling right after T.
  task automatic run_frame(input int extra_at, input bit with_clr, input bit scramble,
                           output int lat, output int lat1, output int busy_n, output bit stable);
    logic [47:0] held;
    held   = out_def;
    stable = 1'b1;
    lat    = -1;
    lat1   = -1;
    busy_n = 0;
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (v_c1 && lat1 < 0) lat1 = c;
      if (v_def) begin
        lat = c;
        break;
      end
      if (b_def) busy_n++;
      if (out_def !== held) stable = 1'b0;
      if (scramble && c == 0) begin
        iSignal = 36'h5A5_A5A_123;
        iCoef   = 24'h37_C4_E9;
      end
      if (c == extra_at) begin
        iStart      = 1'b1;
        iClrOverrun = with_clr;
      end
      tick();
      iStart      = 1'b0;
      iClrOverrun = 1'b0;
    end
  endtask

  int lat, lat1, busy_n, nval;
  bit stable;

  initial begin
    rst_n = 1'b0; iStart = 1'b0; iClrOverrun = 1'b0; iSignal = '0; iCoef = '0;
    tick(); tick();
    check("reset_out", out_def, 48'h0);
    check("reset_valid", v_def, 1'b0);
    check("reset_busy", b_def, 1'b0);
    check("reset_overrun", o_def, 1'b0);
    rst_n = 1'b1;
    tick();

    // Frame A: extreme operands across all builds
    set_ops(2047, 255, -2048, 255, 100, 0);
    run_frame(-1, 1'b0, 1'b0, lat, lat1, busy_n, stable);
    $display("frame A: lat=%0d lat1=%0d busy=%0d out=%h", lat, lat1, busy_n, out_def);
    check("latency_def", lat, 5);
    check("latency_c1", lat1, 3);
    check("busy_cycles", busy_n, 5);
    check("busy_in_valid", b_def, 1'b0);
    check("out_def_A", out_def, 48'h0000_8080_7F70);
    check("out_rnd_A", out_rnd, 48'h0000_8080_7F70);
    check("out_sat_A", out_sat, 48'h0000_8000_7FFF);
    check("out_wrp_A", out_wrp, 48'h0000_0800_F701);
    check("out_c1_A", out_c1, 16'h7F70);
    check("overrun_A", o_def, 1'b0);

    // Frame B: rounding boundary, scrambled inputs during RUN, overrun start
    set_ops(1, 8, -1, 8, -2048, 255);
    run_frame(1, 1'b0, 1'b1, lat, lat1, busy_n, stable);
    $display("frame B: lat=%0d out_def=%h out_rnd=%h ovr=%0b", lat, out_def, out_rnd, o_def);
    check("latency_B", lat, 5);
    check("out_def_B", out_def, 48'h8080_FFFF_0000);
    check("out_rnd_B", out_rnd, 48'h8080_0000_0001);
    check("overrun_set", o_def, 1'b1);
    nval = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (v_def) nval++;
    end
    check("no_extra_valid", nval, 0);
    check("overrun_hold", o_def, 1'b1);
    iClrOverrun = 1'b1;
    tick();
    iClrOverrun = 1'b0;
    $display("clear overrun: ovr=%0b", o_def);
    check("overrun_clr", o_def, 1'b0);

    // Frame C: clear and overrun in the same cycle, then back-to-back frame
    set_ops(2047, 255, -2048, 255, 100, 0);
    run_frame(1, 1'b1, 1'b0, lat, lat1, busy_n, stable);
    $display("frame C: lat=%0d ovr=%0b out=%h", lat, o_def, out_def);
    check("overrun_set_wins", o_def, 1'b1);
    check("out_def_C", out_def, 48'h0000_8080_7F70);
    set_ops(1, 8, -1, 8, -2048, 255);
    run_frame(-1, 1'b0, 1'b0, lat, lat1, busy_n, stable);
    $display("frame D: lat=%0d stable=%0b out=%h", lat, stable, out_def);
    check("latency_b2b", lat, 5);
    check("stable_b2b", stable, 1'b1);
    check("out_def_D", out_def, 48'h8080_FFFF_0000);

    // Reset mid-frame
    set_ops(2047, 255, -2048, 255, 100, 0);
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    #1;
    $display("mid-frame reset: out=%h busy=%0b", out_def, b_def);
    check("rst_mid_out", out_def, 48'h0);
    check("rst_mid_busy", b_def, 1'b0);
    check("rst_mid_ovr", o_def, 1'b0);
    tick();
    rst_n = 1'b1;
    nval = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (v_def) nval++;
    end
    check("rst_no_valid", nval, 0);
    run_frame(-1, 1'b0, 1'b0, lat, lat1, busy_n, stable);
    $display("frame E: lat=%0d out=%h", lat, out_def);
    check("latency_E", lat, 5);
    check("out_def_E", out_def, 48'h0000_8080_7F70);
    check("out_sat_E", out_sat, 48'h0000_8000_7FFF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
